piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per parallel word; legal range 2..32.
REQ-002 Parameter IDLE_BIT, default 1'b1, level driven on d when no word is being shifted.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word to transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 msb_first  input  1  bit order for the word being accepted: 1 = MSB first, 0 = LSB first.
REQ-009 d  output  1  serial data stream to the downstream sequence detector.
REQ-010 d_valid  output  1  d carries a word bit this cycle.
REQ-011 word_done  output  1  high during the cycle the last bit of a word is on d.
REQ-012 busy  output  1  a word is held or is being shifted.

Function
REQ-013 Handshake: a transfer occurs on a rising edge where din_valid and din_ready are both 1; no transfer otherwise.
REQ-014 Storage: one holding register (word, msb_first, hold_valid) plus one shift register with a bit counter of clog2(WIDTH) bits.
REQ-015 din_ready = !hold_valid while reset is low; din_ready = 0 while reset is high.
REQ-016 An accepted word is written to the holding register, with msb_first captured alongside it, and hold_valid is set.
REQ-017 FSM states: IDLE and SHIFT.
REQ-018 IDLE with hold_valid = 1: on the next edge, load the shifter from the holding register, clear hold_valid, set bit_cnt = 0, and go to SHIFT.
REQ-019 IDLE with hold_valid = 0: remain in IDLE.
REQ-020 SHIFT with bit_cnt < WIDTH-1: advance one bit per cycle and increment bit_cnt.
REQ-021 SHIFT with bit_cnt = WIDTH-1 and hold_valid = 1: reload from the holding register on that edge and stay in SHIFT with bit_cnt = 0, giving zero gap between words.
REQ-022 SHIFT with bit_cnt = WIDTH-1 and hold_valid = 0: return to IDLE.
REQ-023 Simultaneous accept and load on one edge: the holding register is loaded with the new word and hold_valid remains 1.
REQ-024 Latency: a word accepted at edge N drives its first bit on d in cycle N+1, when starting from IDLE.
REQ-025 Latency: the last bit of that word is on d in cycle N+WIDTH.
REQ-026 Bit order: the first bit is din[WIDTH-1] if the captured msb_first = 1, else din[0]; each following bit is the next lower or next higher index respectively.
REQ-027 Changes to msb_first after acceptance have no effect on a word already held or being shifted.
REQ-028 d = current shifter bit in SHIFT; d = IDLE_BIT in IDLE.
REQ-029 d_valid = 1 exactly when state = SHIFT.
REQ-030 word_done = 1 exactly when state = SHIFT and bit_cnt = WIDTH-1.
REQ-031 busy = (state = SHIFT) | hold_valid.
REQ-032 While din_ready = 0, din and din_valid are ignored; the word is neither lost nor duplicated once it is accepted.

Reset
REQ-033 On assertion of reset, immediately and regardless of clk: state = IDLE, hold_valid = 0, shifter = 0, bit_cnt = 0.
REQ-034 While reset is asserted, outputs are d = IDLE_BIT, d_valid = 0, word_done = 0, busy = 0 and din_ready = 0.
REQ-035 Reset asserted mid-word aborts both the current word and the held word; no partial bits appear after reset is released.
REQ-036 The first edge after reset is released may accept a word.

Verification
REQ-037 Reset check: assert reset with no clock edge -> d = 1, d_valid = 0, din_ready = 0, busy = 0 in the same cycle.
REQ-038 MSB-first word: din = 8'h77, msb_first = 1, accepted at edge N -> d = 0,1,1,1,0,1,1,1 in cycles N+1..N+8, word_done only in cycle N+8, then d = 1 and d_valid = 0.
REQ-039 LSB-first word: din = 8'hE1, msb_first = 0 -> d = 1,0,0,0,0,1,1,1; verify the downstream detector output y pulses where the pattern 0111 completes.
REQ-040 Back-to-back words: 8'h0F, 8'hF0, 8'hAA with din_valid held high -> d_valid continuously 1 for 24 cycles, 24 bits in order, din_ready low whenever hold_valid = 1, exactly 3 transfers.
REQ-041 Mid-word reset: reset asserted after 3 bits of 8'h77 with a second word held -> d = 1 and busy = 0 at once; after release, a new word 8'h01 shifts from bit 0 with no remnants of either aborted word.
REQ-042 Stall: din_valid high with din = 8'h3C while din_ready = 0 for 5 cycles -> no transfer during the stall; the word is transferred once on the first ready edge and shifted exactly once.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-word holding register, so a new word
// can follow the current one on d without a gap. Bit order is chosen per word.
module piso_serializer #(
   parameter int unsigned WIDTH    = 8,
   parameter logic        IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             msb_first,
   output logic             d,
   output logic             d_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_msb_q, hold_msb_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             shift_msb_q, shift_msb_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

   logic accept;
   logic last_bit;
   logic load;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_msb_d   = hold_msb_q;
      hold_valid_d = hold_valid_q;
      shift_d      = shift_q;
      shift_msb_d  = shift_msb_q;
      bit_cnt_d    = bit_cnt_q;

      accept   = din_valid & din_ready;
      last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST);
      load     = hold_valid_q && ((state_q == IDLE) || last_bit);

      if (state_q == SHIFT) begin
         if (last_bit) begin
            state_d = IDLE;
         end else begin
            shift_d   = shift_msb_q ? (shift_q << 1) : (shift_q >> 1);
            bit_cnt_d = bit_cnt_q + CW'(1);
         end
      end

      // A reload on the last bit overrides the return to IDLE for a gapless stream
      if (load) begin
         state_d      = SHIFT;
         shift_d      = hold_q;
         shift_msb_d  = hold_msb_q;
         bit_cnt_d    = '0;
         hold_valid_d = 1'b0;
      end

      if (accept) begin
         hold_d       = din;
         hold_msb_d   = msb_first;
         hold_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         hold_msb_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         shift_q      <= '0;
         shift_msb_q  <= 1'b0;
         bit_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_msb_q   <= hold_msb_d;
         hold_valid_q <= hold_valid_d;
         shift_q      <= shift_d;
         shift_msb_q  <= shift_msb_d;
         bit_cnt_q    <= bit_cnt_d;
      end
   end

   assign din_ready = ~hold_valid_q & ~reset;
   assign d_valid   = (state_q == SHIFT);
   assign word_done = (state_q == SHIFT) && (bit_cnt_q == LAST);
   assign busy      = (state_q == SHIFT) | hold_valid_q;
   assign d         = (state_q == SHIFT) ? (shift_msb_q ? shift_q[WIDTH-1] : shift_q[0])
                                         : IDLE_BIT;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a queue-of-bits model predicts d and the flags
// each cycle for directed scenarios and a randomized stream.
module tb_piso_serializer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         msb_first;
   logic         d;
   logic         d_valid;
   logic         word_done;
   logic         busy;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .msb_first (msb_first),
      .d         (d),
      .d_valid   (d_valid),
      .word_done (word_done),
      .busy      (busy)
   );

   int errors = 0;
   int checks = 0;
   int dut_xfers = 0;
   int mdl_xfers = 0;

   // Model: bits still to appear on d, plus the pending word as an ordered bit list
   bit mq[$];
   bit mh[$];
   bit mheld = 1'b0;

   logic [31:0] obs;
   int          obs_cnt;
   int          pat_cnt;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic clear_obs();
      obs       = '0;
      obs_cnt   = 0;
      pat_cnt   = 0;
      dut_xfers = 0;
      mdl_xfers = 0;
   endtask

   task automatic check_outs();
      logic exp_d;
      if (mq.size() != 0) exp_d = mq[0];
      else                exp_d = 1'b1;
      chk("d", 32'(d), 32'(exp_d));
      chk("d_valid", 32'(d_valid), 32'(mq.size() != 0));
      chk("word_done", 32'(word_done), 32'(mq.size() == 1));
      chk("busy", 32'(busy), 32'((mq.size() != 0) || mheld));
   endtask

   task automatic step(input logic v, input logic [W-1:0] data, input logic m, output bit acc);
      din_valid = v;
      din       = data;
      msb_first = m;
      @(negedge clk);
      chk("din_ready", 32'(din_ready), 32'(!mheld));
      if (din_valid && din_ready) dut_xfers++;
      acc = v && !mheld;
      if (acc) mdl_xfers++;
      @(posedge clk);
      if (mq.size() != 0) void'(mq.pop_front());
      if (mq.size() == 0 && mheld) begin
         mq    = mh;
         mheld = 1'b0;
      end
      if (acc) begin
         mh.delete();
         for (int i = 0; i < int'(W); i++) mh.push_back(m ? data[W-1-i] : data[i]);
         mheld = 1'b1;
      end
      #1;
      check_outs();
      if (d_valid) begin
         obs = {obs[30:0], d};
         obs_cnt++;
         if (obs_cnt >= 4 && obs[3:0] == 4'b0111) pat_cnt++;
      end
   endtask

   // Called just after a rising edge; reset takes effect with no further edge
   task automatic do_reset();
      reset = 1'b1;
      #1;
      mq.delete();
      mh.delete();
      mheld = 1'b0;
      chk("rst_d", 32'(d), 32'd1);
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_word_done", 32'(word_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_din_ready", 32'(din_ready), 32'd0);
      din_valid = 1'b1;
      din       = 8'hC3;
      @(posedge clk);
      #1;
      chk("rst_hold_d_valid", 32'(d_valid), 32'd0);
      chk("rst_hold_busy", 32'(busy), 32'd0);
      chk("rst_hold_din_ready", 32'(din_ready), 32'd0);
      din_valid = 1'b0;
      reset     = 1'b0;
      clear_obs();
   endtask

   task automatic stream(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                         input logic m, input int cycles);
      logic [W-1:0] words [3];
      int idx;
      bit acc;
      words[0] = w0;
      words[1] = w1;
      words[2] = w2;
      idx = 0;
      for (int c = 0; c < cycles; c++) begin
         if (idx < 3) step(1'b1, words[idx], m, acc);
         else         step(1'b0, '0, m, acc);
         if (acc) idx++;
      end
      chk("stream_words_taken", 32'(idx), 32'd3);
   endtask

   initial begin
      bit acc;
      reset     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      msb_first = 1'b1;
      clear_obs();

      #1 reset = 1'b1;
      #1;
      chk("por_d", 32'(d), 32'd1);
      chk("por_d_valid", 32'(d_valid), 32'd0);
      chk("por_din_ready", 32'(din_ready), 32'd0);
      chk("por_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // MSB-first 8'h77
      clear_obs();
      step(1'b1, 8'h77, 1'b1, acc);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, acc);
      chk("msb77_bits", obs, 32'h77);
      chk("msb77_count", 32'(obs_cnt), 32'd8);
      chk("msb77_det", 32'(pat_cnt), 32'd2);
      chk("msb77_xfers", 32'(dut_xfers), 32'(mdl_xfers));

      // LSB-first 8'hE1, msb_first flipped after acceptance
      clear_obs();
      step(1'b1, 8'hE1, 1'b0, acc);
      for (int i = 0; i < 11; i++) step(1'b0, 8'hFF, 1'b1, acc);
      chk("lsbE1_bits", obs, 32'h87);
      chk("lsbE1_det", 32'(pat_cnt), 32'd1);

      // Back-to-back with din_valid held
      clear_obs();
      stream(8'h0F, 8'hF0, 8'hAA, 1'b1, 32);
      chk("b2b_bits", obs, 32'h000FF0AA);
      chk("b2b_count", 32'(obs_cnt), 32'd24);
      chk("b2b_xfers", 32'(dut_xfers), 32'd3);

      // Mid-word reset with a second word held, then a fresh LSB-first word
      clear_obs();
      step(1'b1, 8'h77, 1'b1, acc);
      step(1'b1, 8'hA5, 1'b1, acc);
      step(1'b1, 8'hA5, 1'b1, acc);
      step(1'b0, 8'h00, 1'b1, acc);
      chk("pre_rst_count", 32'(obs_cnt), 32'd3);
      do_reset();
      step(1'b1, 8'h01, 1'b0, acc);
      chk("post_rst_accept", 32'(dut_xfers), 32'd1);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, acc);
      chk("post_rst_bits", obs, 32'h80);
      chk("post_rst_count", 32'(obs_cnt), 32'd8);

      // Stall: 8'h3C waits behind a shifting word and a held word
      clear_obs();
      stream(8'h55, 8'h66, 8'h3C, 1'b1, 34);
      chk("stall_bits", obs, 32'h0055663C);
      chk("stall_count", 32'(obs_cnt), 32'd24);
      chk("stall_xfers", 32'(dut_xfers), 32'd3);

      // Randomized traffic with occasional resets
      clear_obs();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step(logic'($urandom_range(0, 3) != 0), W'($urandom), logic'($urandom_range(0, 1)), acc);
         end
         chk("rand_xfers", 32'(dut_xfers), 32'(mdl_xfers));
      end
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
